pipe_stage_skid: RTL and testbench
==================================

# pipe_stage_skid

Parametrised pipeline stage register for the pipelined TSC CPU datapath. It is the successor to the fixed per-stage latches. It carries a generic control field and data field between two pipeline stages using a valid/ready handshake, with a 2-entry skid buffer so upstream ready is registered. Synchronous flush turns the stage into a bubble, and halt freezes it. A saturating stall counter supports performance debug. One instance per stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).

## Interface
Parameters:
- DATA_W, default 16: width of the data field (PC, operands, immediates concatenated by the instantiating stage).
- CTRL_W, default 8: width of the control field (RegWrite, MemRead, MemWrite, Halt, ...).
- CTRL_BUBBLE, default 0 (CTRL_W bits): control value presented whenever the stage holds no valid entry.
- STALL_CNT_W, default 16: width of the stall counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; discards both entries.
- halt  in  1  synchronous; freezes all state and blocks both handshakes.
- in_valid  in  1  upstream entry offered.
- in_ready  out  1  stage can accept an entry.
- in_ctrl  in  CTRL_W  upstream control field.
- in_data  in  DATA_W  upstream data field.
- out_valid  out  1  entry presented downstream.
- out_ready  in  1  downstream accepts the entry.
- out_ctrl  out  CTRL_W  control field; equals CTRL_BUBBLE when out_valid=0.
- out_data  out  DATA_W  data field; equals 0 when out_valid=0.
- occupancy  out  2  number of valid entries (0, 1 or 2).
- stall_cycles  out  STALL_CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

## Operation
- Storage: main entry (main_v, main_ctrl, main_data) drives the outputs. Skid entry (skid_v, skid_ctrl, skid_data) absorbs one entry when downstream stalls.
- State is encoded by {skid_v, main_v}: EMPTY=00, ONE=01, TWO=11. The value 10 is illegal and never reached.
- Handshake signals:
  - in_ready = !skid_v && !halt.
  - out_valid = main_v && !halt.
  - An accept is in_valid && in_ready; a send is out_valid && out_ready.
- Transitions (halt=0, flush=0):
  - EMPTY: accept → main<=in, go to ONE.
  - ONE, accept and send → main<=in, stay in ONE.
  - ONE, send only → EMPTY.
  - ONE, accept only → skid<=in, go to TWO.
  - ONE, neither → hold.
  - TWO (in_ready=0): send → main<=skid, skid_v<=0, go to ONE. Otherwise hold.
- Priority: flush > halt > normal operation.
  - flush=1: main_v<=0, skid_v<=0, both ctrl<=CTRL_BUBBLE, both data<=0, regardless of halt or in_valid. An input offered in the flush cycle is dropped.
  - halt=1, flush=0: every register, including stall_cycles, holds its value.
- Output masking: when main_v=0, out_ctrl=CTRL_BUBBLE and out_data=0 (bubble insertion).
- Ordering: entries leave in acceptance order. No entry is lost or duplicated outside flush.
- stall_cycles:
  - Increments by 1 when out_valid && !out_ready and flush=0.
  - Saturates at all-ones.
  - Cleared only by reset; not cleared by flush.

## Timing
- Reset (async assert, sync-safe deassert): main_v=skid_v=0, ctrl=CTRL_BUBBLE, data=0, stall_cycles=0. After reset: out_valid=0, in_ready=1 (if halt=0), out_ctrl=CTRL_BUBBLE, out_data=0, occupancy=0.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock edge.
- Latency: an entry accepted at edge N is on out_* after edge N, so out_valid is visible in cycle N+1.
- Throughput: 1 entry/cycle sustained while out_ready=1.
- Upstream backpressure: in_ready falls one cycle after the first stalled accept, because the skid absorbs that in-flight entry.
- After a stall releases, in_ready returns one cycle after the first send out of TWO.
- in_ready and out_valid depend combinationally only on registers and halt, never on in_valid or out_ready.
- occupancy = main_v + skid_v, registered.

## Test plan
- Streaming: out_ready=1, accept ctrl/data 0x01/0x1111, 0x02/0x2222, 0x03/0x3333 on consecutive edges → same values appear on out_* one cycle later each. occupancy stays 1. stall_cycles=0.
- Backpressure: hold out_ready=0 while offering A, B, C → A in main, B in skid, in_ready=0, C held upstream, occupancy=2. stall_cycles increments each cycle. Release → A, B, C emitted in order.
- Flush in TWO: occupancy=2, pulse flush with in_valid=1 → next cycle occupancy=0, out_valid=0, out_ctrl=CTRL_BUBBLE, out_data=0. The offered input is dropped. stall_cycles retained.
- Halt: stage in ONE holding 0x5A5A, halt=1 for 3 cycles with in_valid=1 and out_ready=1 → in_ready=0, out_valid=0, no state change. Deasserting halt re-presents 0x5A5A.
- Saturation: STALL_CNT_W=4, hold a stall for 20 cycles → stall_cycles stops at 15.
- Async reset mid-stream: assert reset_n=0 between edges while in TWO → outputs go to reset values immediately. Release → in_ready=1, occupancy=0.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a valid/ready handshake and a 2-entry skid buffer.
// Supports synchronous flush (bubble), halt (freeze) and a saturating stall counter.
module pipe_stage_skid #(
  parameter int unsigned          DATA_W      = 16,
  parameter int unsigned          CTRL_W      = 8,
  parameter logic [CTRL_W-1:0]    CTRL_BUBBLE = '0,
  parameter int unsigned          STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   halt,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CTRL_W-1:0]      in_ctrl,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [DATA_W-1:0]      out_data,
  output logic [1:0]             occupancy,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  // State bits are {skid_v, main_v}; 2'b10 is unreachable.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b11
  } state_t;

  state_t                 r_state,     w_state_nxt;
  logic [CTRL_W-1:0]      r_main_ctrl, w_main_ctrl_nxt;
  logic [DATA_W-1:0]      r_main_data, w_main_data_nxt;
  logic [CTRL_W-1:0]      r_skid_ctrl, w_skid_ctrl_nxt;
  logic [DATA_W-1:0]      r_skid_data, w_skid_data_nxt;
  logic [STALL_CNT_W-1:0] r_stall,     w_stall_nxt;
  logic [1:0]             r_occ,       w_occ_nxt;
  logic [1:0]             w_state_bits_nxt;
  logic                   w_main_v;
  logic                   w_skid_v;
  logic                   w_accept;
  logic                   w_send;

  assign w_main_v  = r_state[0];
  assign w_skid_v  = r_state[1];

  // Handshakes depend only on registers and halt, never on the peer's valid/ready.
  assign in_ready  = !w_skid_v && !halt;
  assign out_valid = w_main_v && !halt;
  assign w_accept  = in_valid && in_ready;
  assign w_send    = out_valid && out_ready;

  assign out_ctrl     = w_main_v ? r_main_ctrl : CTRL_BUBBLE;
  assign out_data     = w_main_v ? r_main_data : DATA_W'(0);
  assign occupancy    = r_occ;
  assign stall_cycles = r_stall;

  // Next-state and datapath selection.
  always_comb begin
    w_state_nxt     = r_state;
    w_main_ctrl_nxt = r_main_ctrl;
    w_main_data_nxt = r_main_data;
    w_skid_ctrl_nxt = r_skid_ctrl;
    w_skid_data_nxt = r_skid_data;

    if (flush) begin
      w_state_nxt     = ST_EMPTY;
      w_main_ctrl_nxt = CTRL_BUBBLE;
      w_main_data_nxt = DATA_W'(0);
      w_skid_ctrl_nxt = CTRL_BUBBLE;
      w_skid_data_nxt = DATA_W'(0);
    end else if (!halt) begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_nxt     = ST_ONE;
            w_main_ctrl_nxt = in_ctrl;
            w_main_data_nxt = in_data;
          end
        end
        ST_ONE: begin
          if (w_accept && w_send) begin
            w_main_ctrl_nxt = in_ctrl;
            w_main_data_nxt = in_data;
          end else if (w_send) begin
            w_state_nxt     = ST_EMPTY;
            w_main_ctrl_nxt = CTRL_BUBBLE;
            w_main_data_nxt = DATA_W'(0);
          end else if (w_accept) begin
            w_state_nxt     = ST_TWO;
            w_skid_ctrl_nxt = in_ctrl;
            w_skid_data_nxt = in_data;
          end
        end
        ST_TWO: begin
          if (w_send) begin
            w_state_nxt     = ST_ONE;
            w_main_ctrl_nxt = r_skid_ctrl;
            w_main_data_nxt = r_skid_data;
            w_skid_ctrl_nxt = CTRL_BUBBLE;
            w_skid_data_nxt = DATA_W'(0);
          end
        end
        default: begin
          w_state_nxt     = ST_EMPTY;
          w_main_ctrl_nxt = CTRL_BUBBLE;
          w_main_data_nxt = DATA_W'(0);
          w_skid_ctrl_nxt = CTRL_BUBBLE;
          w_skid_data_nxt = DATA_W'(0);
        end
      endcase
    end
  end

  // Stall counter and registered occupancy.
  always_comb begin
    w_stall_nxt = r_stall;
    if (!flush && out_valid && !out_ready && (r_stall != {STALL_CNT_W{1'b1}}))
      w_stall_nxt = r_stall + STALL_CNT_W'(1);
    w_state_bits_nxt = w_state_nxt;
    w_occ_nxt        = 2'(w_state_bits_nxt[0]) + 2'(w_state_bits_nxt[1]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_EMPTY;
      r_main_ctrl <= CTRL_BUBBLE;
      r_main_data <= DATA_W'(0);
      r_skid_ctrl <= CTRL_BUBBLE;
      r_skid_data <= DATA_W'(0);
      r_stall     <= STALL_CNT_W'(0);
      r_occ       <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_main_ctrl <= w_main_ctrl_nxt;
      r_main_data <= w_main_data_nxt;
      r_skid_ctrl <= w_skid_ctrl_nxt;
      r_skid_data <= w_skid_data_nxt;
      r_stall     <= w_stall_nxt;
      r_occ       <= w_occ_nxt;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid (4-bit stall counter, nonzero bubble).
module tb_pipe_stage_skid;

  localparam logic [7:0] BUB = 8'hE0;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic        halt;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_ctrl;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_ctrl;
  logic [15:0] out_data;
  logic [1:0]  occupancy;
  logic [3:0]  stall_cycles;

  int n_checks;
  int n_fail;

  pipe_stage_skid #(
    .DATA_W(16), .CTRL_W(8), .CTRL_BUBBLE(BUB), .STALL_CNT_W(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .halt(halt),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    flush = 0; halt = 0; in_valid = 0; out_ready = 0; in_ctrl = 0; in_data = 0;
    reset_n = 0;
    @(negedge clk);
    reset_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks += 6;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    if (out_ctrl !== BUB) begin n_fail++; $display("FAIL reset_out_ctrl got %h exp %h", out_ctrl, BUB); end
    if (out_data !== 16'h0) begin n_fail++; $display("FAIL reset_out_data got %h exp 0", out_data); end
    if (occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
    if (stall_cycles !== 4'd0) begin n_fail++; $display("FAIL reset_stall got %0d exp 0", stall_cycles); end
  endtask

  task automatic test_streaming();
    logic [7:0]  ctl [3];
    logic [15:0] dat [3];
    ctl[0] = 8'h01; dat[0] = 16'h1111;
    ctl[1] = 8'h02; dat[1] = 16'h2222;
    ctl[2] = 8'h03; dat[2] = 16'h3333;
    do_reset();
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_ctrl = ctl[i]; in_data = dat[i];
      tick();
      n_checks += 5;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d] got %b exp 1", i, out_valid); end
      if (out_ctrl !== ctl[i]) begin n_fail++; $display("FAIL stream_ctrl[%0d] got %h exp %h", i, out_ctrl, ctl[i]); end
      if (out_data !== dat[i]) begin n_fail++; $display("FAIL stream_data[%0d] got %h exp %h", i, out_data, dat[i]); end
      if (occupancy !== 2'd1) begin n_fail++; $display("FAIL stream_occ[%0d] got %0d exp 1", i, occupancy); end
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready[%0d] got %b exp 1", i, in_ready); end
    end
    in_valid = 0;
    tick();
    n_checks += 4;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain_valid got %b exp 0", out_valid); end
    if (out_data !== 16'h0) begin n_fail++; $display("FAIL stream_drain_data got %h exp 0", out_data); end
    if (occupancy !== 2'd0) begin n_fail++; $display("FAIL stream_drain_occ got %0d exp 0", occupancy); end
    if (stall_cycles !== 4'd0) begin n_fail++; $display("FAIL stream_stall got %0d exp 0", stall_cycles); end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 0;
    in_valid = 1; in_ctrl = 8'h0A; in_data = 16'hAAAA;
    tick();
    n_checks += 3;
    if (out_data !== 16'hAAAA) begin n_fail++; $display("FAIL bp_a_main got %h exp aaaa", out_data); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_one_in_ready got %b exp 1", in_ready); end
    if (stall_cycles !== 4'd0) begin n_fail++; $display("FAIL bp_stall0 got %0d exp 0", stall_cycles); end
    in_ctrl = 8'h0B; in_data = 16'hBBBB;
    tick();
    n_checks += 4;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_two_in_ready got %b exp 0", in_ready); end
    if (occupancy !== 2'd2) begin n_fail++; $display("FAIL bp_two_occ got %0d exp 2", occupancy); end
    if (out_data !== 16'hAAAA) begin n_fail++; $display("FAIL bp_two_main got %h exp aaaa", out_data); end
    if (stall_cycles !== 4'd1) begin n_fail++; $display("FAIL bp_stall1 got %0d exp 1", stall_cycles); end
    in_ctrl = 8'h0C; in_data = 16'hCCCC;
    tick();
    tick();
    n_checks += 3;
    if (out_ctrl !== 8'h0A) begin n_fail++; $display("FAIL bp_hold_ctrl got %h exp 0a", out_ctrl); end
    if (occupancy !== 2'd2) begin n_fail++; $display("FAIL bp_hold_occ got %0d exp 2", occupancy); end
    if (stall_cycles !== 4'd3) begin n_fail++; $display("FAIL bp_stall3 got %0d exp 3", stall_cycles); end
    out_ready = 1;
    tick();
    n_checks += 4;
    if (out_data !== 16'hBBBB) begin n_fail++; $display("FAIL bp_rel_b got %h exp bbbb", out_data); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_rel_in_ready got %b exp 1", in_ready); end
    if (occupancy !== 2'd1) begin n_fail++; $display("FAIL bp_rel_occ got %0d exp 1", occupancy); end
    if (stall_cycles !== 4'd3) begin n_fail++; $display("FAIL bp_rel_stall got %0d exp 3", stall_cycles); end
    tick();
    n_checks += 2;
    if (out_data !== 16'hCCCC) begin n_fail++; $display("FAIL bp_rel_c got %h exp cccc", out_data); end
    if (out_ctrl !== 8'h0C) begin n_fail++; $display("FAIL bp_rel_c_ctrl got %h exp 0c", out_ctrl); end
    in_valid = 0;
    tick();
    n_checks += 2;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain_valid got %b exp 0", out_valid); end
    if (occupancy !== 2'd0) begin n_fail++; $display("FAIL bp_drain_occ got %0d exp 0", occupancy); end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 0;
    in_valid = 1; in_ctrl = 8'h11; in_data = 16'h1234;
    tick();
    in_ctrl = 8'h22; in_data = 16'h5678;
    tick();
    flush = 1; in_ctrl = 8'h33; in_data = 16'h9ABC;
    tick();
    flush = 0; in_valid = 0;
    n_checks += 6;
    if (occupancy !== 2'd0) begin n_fail++; $display("FAIL flush_occ got %0d exp 0", occupancy); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b exp 0", out_valid); end
    if (out_ctrl !== BUB) begin n_fail++; $display("FAIL flush_ctrl got %h exp %h", out_ctrl, BUB); end
    if (out_data !== 16'h0) begin n_fail++; $display("FAIL flush_data got %h exp 0", out_data); end
    if (stall_cycles !== 4'd1) begin n_fail++; $display("FAIL flush_stall got %0d exp 1", stall_cycles); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready got %b exp 1", in_ready); end
    tick();
    n_checks += 1;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_dropped got %b exp 0", out_valid); end
  endtask

  task automatic test_halt();
    do_reset();
    out_ready = 1;
    in_valid = 1; in_ctrl = 8'h5A; in_data = 16'h5A5A;
    tick();
    halt = 1; in_ctrl = 8'h77; in_data = 16'h7777;
    #1;
    n_checks += 2;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL halt_comb_in_ready got %b exp 0", in_ready); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL halt_comb_valid got %b exp 0", out_valid); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks += 4;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL halt_in_ready[%0d] got %b exp 0", i, in_ready); end
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL halt_valid[%0d] got %b exp 0", i, out_valid); end
      if (occupancy !== 2'd1) begin n_fail++; $display("FAIL halt_occ[%0d] got %0d exp 1", i, occupancy); end
      if (out_data !== 16'h5A5A) begin n_fail++; $display("FAIL halt_data[%0d] got %h exp 5a5a", i, out_data); end
    end
    halt = 0; in_valid = 0;
    #1;
    n_checks += 3;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL unhalt_valid got %b exp 1", out_valid); end
    if (out_data !== 16'h5A5A) begin n_fail++; $display("FAIL unhalt_data got %h exp 5a5a", out_data); end
    if (stall_cycles !== 4'd0) begin n_fail++; $display("FAIL halt_stall got %0d exp 0", stall_cycles); end
    tick();
    n_checks += 1;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL unhalt_send got %b exp 0", out_valid); end
  endtask

  task automatic test_saturation();
    int exp_cnt;
    do_reset();
    out_ready = 0;
    in_valid = 1; in_ctrl = 8'h44; in_data = 16'h4444;
    tick();
    in_valid = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp_cnt = (k > 15) ? 15 : k;
      n_checks += 1;
      if (stall_cycles !== 4'(exp_cnt)) begin
        n_fail++; $display("FAIL sat_cnt[%0d] got %0d exp %0d", k, stall_cycles, exp_cnt);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 0;
    in_valid = 1; in_ctrl = 8'h66; in_data = 16'h6666;
    tick();
    in_data = 16'h6767;
    tick();
    n_checks += 1;
    if (occupancy !== 2'd2) begin n_fail++; $display("FAIL ar_pre_occ got %0d exp 2", occupancy); end
    #2 reset_n = 0;
    #1;
    n_checks += 5;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid got %b exp 0", out_valid); end
    if (occupancy !== 2'd0) begin n_fail++; $display("FAIL ar_occ got %0d exp 0", occupancy); end
    if (stall_cycles !== 4'd0) begin n_fail++; $display("FAIL ar_stall got %0d exp 0", stall_cycles); end
    if (out_ctrl !== BUB) begin n_fail++; $display("FAIL ar_ctrl got %h exp %h", out_ctrl, BUB); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ar_in_ready got %b exp 1", in_ready); end
    in_valid = 0;
    #2 reset_n = 1;
    tick();
    n_checks += 2;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ar_rel_in_ready got %b exp 1", in_ready); end
    if (occupancy !== 2'd0) begin n_fail++; $display("FAIL ar_rel_occ got %0d exp 0", occupancy); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_halt();
    test_saturation();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
